// File: rtl/ppu_pkg.sv
// Shared constants and types for the PPU row-RAM double buffer.
// Sizes follow the 320x240 visible frame with 10-bit palette indices.
package ppu_pkg;

    localparam int ROW_W  = 320;
    localparam int ROWS   = 240;
    localparam int PIX_W  = 10;
    localparam int ADDR_W = 9;
    localparam int ROWN_W = 8;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} rowbuf_state_t;

    typedef logic [PIX_W-1:0] pix_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        pix_t              data;
    } ram_wr_t;

    // Rows at or past the visible count mean "nothing to fetch".
    function automatic logic is_fill_row(input logic [ROWN_W-1:0] r);
        return r < ROWN_W'(ROWS);
    endfunction

endpackage

// File: rtl/ppu_rowram_buffer_if.sv
// Row-RAM read port, frame strobes, row request and pixel stream of the buffer.
// The buffer is the slave; the display block and pixel pipeline form the master.
interface ppu_rowram_buffer_if;
    import ppu_pkg::*;

    logic [ADDR_W-1:0] rowram_rdaddr;
    pix_t              rowram_rddata;
    logic              rowram_swap;
    logic              vblank_start;
    logic              vblank_end_soon;
    logic [ROWN_W-1:0] next_row;
    logic              row_req_valid;
    logic [ROWN_W-1:0] row_req_num;
    logic              row_req_ready;
    logic              pix_valid;
    pix_t              pix_data;
    logic              pix_ready;
    logic              row_done;
    logic              overrun;

    modport master (
        output rowram_rdaddr, rowram_swap, vblank_start, vblank_end_soon, next_row,
        output row_req_ready, pix_valid, pix_data,
        input  rowram_rddata, row_req_valid, row_req_num, pix_ready, row_done, overrun
    );

    modport slave (
        input  rowram_rdaddr, rowram_swap, vblank_start, vblank_end_soon, next_row,
        input  row_req_ready, pix_valid, pix_data,
        output rowram_rddata, row_req_valid, row_req_num, pix_ready, row_done, overrun
    );

endinterface

// File: rtl/rowram_bank.sv
// One row bank: simple dual-port 1R1W RAM with a registered read, maps to block RAM.
module rowram_bank
    import ppu_pkg::*;
(
    input  logic              clk,
    input  ram_wr_t           wr,
    input  logic [ADDR_W-1:0] rd_addr,
    output pix_t              rd_data
);

    pix_t mem [ROW_W];
    pix_t rd_q;

    // No reset on the array or read register so the tools keep it in block RAM.
    always_ff @(posedge clk) begin
        if (wr.we) mem[wr.addr] <= wr.data;
        rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/ppu_rowram_buffer.sv
// Double-buffered row RAM: display reads one bank while the other is filled
// from the PPU pixel pipeline under control of swap/vblank strobes.
module ppu_rowram_buffer
    import ppu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ppu_rowram_buffer_if.slave  bus
);

    rowbuf_state_t     state_q, state_d;
    logic              disp_bank_q, disp_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ROWN_W-1:0] row_req_num_q, row_req_num_d;
    logic              row_req_valid_q, row_req_valid_d;
    logic              pix_ready_q, pix_ready_d;
    logic              row_done_q, row_done_d;
    logic              overrun_q, overrun_d;
    logic              rd_sel_q, rd_sel_d;
    logic              rd_zero_q, rd_zero_d;
    logic [1:0]        written_q, written_d;

    ram_wr_t [1:0]     bank_wr;
    pix_t    [1:0]     bank_rd;

    logic              frame_evt;
    logic              fill_busy;
    logic              start_fill;
    logic              pix_fire;
    logic              wr_en;

    always_comb begin
        frame_evt  = bus.rowram_swap || bus.vblank_start || bus.vblank_end_soon;
        fill_busy  = (state_q == REQ) || (state_q == FILL);
        pix_fire   = bus.pix_valid && pix_ready_q;
        // A pixel landing on the same cycle as a frame strobe belongs to the aborted fill.
        wr_en      = pix_fire && (state_q == FILL) && !frame_evt;

        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        row_req_num_d = row_req_num_q;
        row_done_d    = 1'b0;
        overrun_d     = overrun_q || (frame_evt && fill_busy);
        disp_bank_d   = disp_bank_q ^ bus.rowram_swap;
        start_fill    = 1'b0;

        if (bus.vblank_start) begin
            state_d = IDLE;
        end else if (bus.rowram_swap) begin
            if (is_fill_row(bus.next_row)) start_fill = 1'b1;
            else                           state_d    = IDLE;
        end else if (bus.vblank_end_soon) begin
            start_fill = 1'b1;
        end else begin
            case (state_q)
                REQ: begin
                    if (row_req_valid_q && bus.row_req_ready) state_d = FILL;
                end
                FILL: begin
                    if (wr_en) begin
                        if (wr_ptr_q == ADDR_W'(ROW_W - 1)) begin
                            wr_ptr_d   = '0;
                            row_done_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            wr_ptr_d = wr_ptr_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (start_fill) begin
            state_d       = REQ;
            wr_ptr_d      = '0;
            row_req_num_d = bus.next_row;
        end

        row_req_valid_d = (state_d == REQ);
        pix_ready_d     = (state_d == FILL);

        // Fills always target the bank the display is not reading.
        bank_wr[0].we   = wr_en && disp_bank_q;
        bank_wr[1].we   = wr_en && !disp_bank_q;
        bank_wr[0].addr = wr_ptr_q;
        bank_wr[1].addr = wr_ptr_q;
        bank_wr[0].data = bus.pix_data;
        bank_wr[1].data = bus.pix_data;
        written_d       = written_q | {bank_wr[1].we, bank_wr[0].we};

        // A bank never written since reset reads as zero, as do out-of-row addresses.
        rd_sel_d  = disp_bank_q;
        rd_zero_d = (bus.rowram_rdaddr >= ADDR_W'(ROW_W)) || !written_q[disp_bank_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            disp_bank_q     <= 1'b0;
            wr_ptr_q        <= '0;
            row_req_num_q   <= '0;
            row_req_valid_q <= 1'b0;
            pix_ready_q     <= 1'b0;
            row_done_q      <= 1'b0;
            overrun_q       <= 1'b0;
            rd_sel_q        <= 1'b0;
            rd_zero_q       <= 1'b1;
            written_q       <= '0;
        end else begin
            state_q         <= state_d;
            disp_bank_q     <= disp_bank_d;
            wr_ptr_q        <= wr_ptr_d;
            row_req_num_q   <= row_req_num_d;
            row_req_valid_q <= row_req_valid_d;
            pix_ready_q     <= pix_ready_d;
            row_done_q      <= row_done_d;
            overrun_q       <= overrun_d;
            rd_sel_q        <= rd_sel_d;
            rd_zero_q       <= rd_zero_d;
            written_q       <= written_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        rowram_bank u_bank (
            .clk     (clk),
            .wr      (bank_wr[b]),
            .rd_addr (bus.rowram_rdaddr),
            .rd_data (bank_rd[b])
        );
    end

    assign bus.rowram_rddata = rd_zero_q ? '0 : bank_rd[rd_sel_q];
    assign bus.row_req_valid = row_req_valid_q;
    assign bus.row_req_num   = row_req_num_q;
    assign bus.pix_ready     = pix_ready_q;
    assign bus.row_done      = row_done_q;
    assign bus.overrun       = overrun_q;

endmodule

// File: tb/tb_ppu_rowram_buffer.sv
// Bench for ppu_rowram_buffer: read expectations are queued when an address is
// driven and compared when the registered read data appears.
module tb_ppu_rowram_buffer;
    import ppu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ppu_rowram_buffer_if bus();

    ppu_rowram_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    int   exp_q[$];
    logic rd_tag   = 1'b0;
    logic launched = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int val(input int r, input int c);
        return (c + 37 * r) % 1024;
    endfunction

    always @(posedge clk) launched <= rd_tag;

    always @(negedge clk) begin
        if (launched) begin
            if (exp_q.size() == 0) begin
                chk("rd_queue_empty", 32'd0, 32'd1);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("rddata", 32'(bus.rowram_rddata), 32'(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int addr, input int exp);
        bus.rowram_rdaddr = 9'(addr);
        rd_tag = 1'b1;
        exp_q.push_back(exp);
        step();
        rd_tag = 1'b0;
    endtask

    task automatic pulse_swap(input int nr);
        bus.next_row    = 8'(nr);
        bus.rowram_swap = 1'b1;
        step();
        bus.rowram_swap = 1'b0;
    endtask

    // Waits for the row request, optionally stalls acceptance, then streams n pixels.
    task automatic fill_row(input int row, input int n, input bit toggle, input int hold);
        int t, col, cnt, cyc;
        logic acc;
        t = 0;
        while (!bus.row_req_valid && t < 50) begin step(); t++; end
        chk("req_valid", 32'(bus.row_req_valid), 32'd1);
        chk("req_num", 32'(bus.row_req_num), 32'(row));
        for (int h = 0; h < hold; h++) begin
            bus.pix_valid = (h % 2 == 0);
            bus.pix_data  = 10'(val(row, 0));
            @(negedge clk);
            chk("no_wr_before_acc", 32'(bus.pix_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        bus.pix_valid     = 1'b0;
        bus.row_req_ready = 1'b1;
        step();
        bus.row_req_ready = 1'b0;
        col = 0; cnt = 0; cyc = 0;
        while (cnt < n && cyc < 2000) begin
            bus.pix_data  = 10'(val(row, col));
            bus.pix_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            @(negedge clk);
            acc = bus.pix_valid && bus.pix_ready;
            @(posedge clk);
            #1;
            if (acc) begin col++; cnt++; end
            cyc++;
        end
        bus.pix_valid = 1'b0;
        chk("wr_count", 32'(cnt), 32'(n));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rowram_rdaddr   = '0;
        bus.rowram_swap     = 1'b0;
        bus.vblank_start    = 1'b0;
        bus.vblank_end_soon = 1'b0;
        bus.next_row        = '0;
        bus.row_req_ready   = 1'b0;
        bus.pix_valid       = 1'b0;
        bus.pix_data        = '0;

        rst = 1'b1;
        repeat (3) step();
        chk("rst_rddata", 32'(bus.rowram_rddata), 32'd0);
        chk("rst_req_valid", 32'(bus.row_req_valid), 32'd0);
        chk("rst_req_num", 32'(bus.row_req_num), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
        chk("rst_row_done", 32'(bus.row_done), 32'd0);
        chk("rst_overrun", 32'(bus.overrun), 32'd0);
        rst = 1'b0;
        step();
        for (int a = 0; a < ROW_W; a++) rd(a, 0);
        rd(320, 0);

        // First visible row prefetch into bank 1.
        bus.next_row = 8'd0;
        bus.vblank_end_soon = 1'b1;
        step();
        bus.vblank_end_soon = 1'b0;
        fill_row(0, ROW_W, 1'b0, 0);
        chk("row_done_pulse", 32'(bus.row_done), 32'd1);
        chk("pix_ready_drop", 32'(bus.pix_ready), 32'd0);
        step();
        chk("row_done_end", 32'(bus.row_done), 32'd0);
        rd(5, 0);

        // Swap: row 0 now visible, row 1 fills bank 0, then abort after 100 pixels.
        pulse_swap(1);
        rd(5, 5);
        rd(319, 319);
        rd(320, 0);
        fill_row(1, 100, 1'b0, 0);
        chk("overrun_pre", 32'(bus.overrun), 32'd0);

        pulse_swap(2);
        chk("overrun_set", 32'(bus.overrun), 32'd1);
        chk("restart_valid", 32'(bus.row_req_valid), 32'd1);
        chk("restart_num", 32'(bus.row_req_num), 32'd2);
        rd(50, val(1, 50));
        rd(99, val(1, 99));
        fill_row(2, ROW_W, 1'b1, 3);
        chk("row_done_toggle", 32'(bus.row_done), 32'd1);
        step();

        // Swap to an invisible row, then vblank: one toggle, no request.
        pulse_swap(240);
        chk("idle_req_valid", 32'(bus.row_req_valid), 32'd0);
        chk("idle_pix_ready", 32'(bus.pix_ready), 32'd0);
        for (int a = 0; a < ROW_W; a++) rd(a, val(2, a));
        rd(320, 0);
        bus.vblank_start = 1'b1;
        step();
        bus.vblank_start = 1'b0;
        rd(7, val(2, 7));
        chk("vblank_req_valid", 32'(bus.row_req_valid), 32'd0);

        // Swap together with vblank_start: toggles, stays idle.
        bus.next_row     = 8'd5;
        bus.rowram_swap  = 1'b1;
        bus.vblank_start = 1'b1;
        step();
        bus.rowram_swap  = 1'b0;
        bus.vblank_start = 1'b0;
        repeat (3) step();
        chk("swapvb_req_valid", 32'(bus.row_req_valid), 32'd0);
        rd(50, val(1, 50));

        // Pixel offered on the same cycle as a swap must be dropped.
        bus.next_row = 8'd3;
        bus.vblank_end_soon = 1'b1;
        step();
        bus.vblank_end_soon = 1'b0;
        fill_row(3, 10, 1'b0, 0);
        bus.pix_valid   = 1'b1;
        bus.pix_data    = 10'(val(3, 10));
        bus.next_row    = 8'd4;
        bus.rowram_swap = 1'b1;
        step();
        bus.rowram_swap = 1'b0;
        bus.pix_valid   = 1'b0;
        chk("drop_req_num", 32'(bus.row_req_num), 32'd4);
        rd(9, val(3, 9));
        rd(10, val(2, 10));

        step();
        step();
        chk("rd_drain", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ppu_rowram_buffer.md
Name: ppu_rowram_buffer

Overview:
PPU-side responder to the HDMI output block's row-RAM interface. Holds a double-buffered row RAM of 320 x 10-bit palette indices. It serves the display side's synchronous reads from the display bank. In parallel it fills the other bank by pulling a pixel stream from the PPU pixel pipeline, using the swap, vblank and next_row strobes. All display-side strobes arrive already synchronised into clk.

Parameters:
ROW_W, 320, pixels per row (entries per bank)
ROWS, 240, visible rows; next_row >= ROWS means no fill
PIX_W, 10, bits per pixel entry (palette index)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rowram_rdaddr  in  9  display-side read address
rowram_rddata  out  PIX_W  read data, 1-cycle latency
rowram_swap  in  1  1-cycle pulse: swap banks, start next fill
vblank_start  in  1  1-cycle pulse: vertical blank begins
vblank_end_soon  in  1  1-cycle pulse: prefetch first visible row
next_row  in  8  row number to fill, valid with swap/vblank_end_soon
row_req_valid  out  1  request to pixel pipeline for row row_req_num
row_req_num  out  8  row being requested
row_req_ready  in  1  pipeline accepts request
pix_valid  in  1  pixel stream valid
pix_data  in  PIX_W  pixel palette index, in column order 0..ROW_W-1
pix_ready  out  1  buffer accepts pixel
row_done  out  1  1-cycle pulse: write bank fully written
overrun  out  1  sticky: swap/vblank arrived before fill completed

Behaviour:
- Reset: disp_bank=0, state IDLE, wr_ptr=0. Outputs rowram_rddata=0, row_req_valid=0, row_req_num=0, pix_ready=0, row_done=0, overrun=0. RAM contents undefined.
- Read port: rowram_rddata <= bank[disp_bank][rowram_rdaddr] one cycle after the address. Address >= ROW_W returns 0. The swap takes effect on reads issued the cycle after the swap pulse.
- Write bank is always ~disp_bank. Pixel writes never touch disp_bank.
- States: IDLE, REQ, FILL, DONE.
- Fill start (rowram_swap with next_row < ROWS, or vblank_end_soon): latch row_req_num <= next_row, wr_ptr <= 0, go to REQ.
- REQ: row_req_valid=1. The request is accepted on the cycle with row_req_valid and row_req_ready both high, then go to FILL.
- FILL: pix_ready=1. Each pix_valid&&pix_ready cycle writes pix_data at wr_ptr and increments wr_ptr. On the write with wr_ptr==ROW_W-1: row_done pulses the next cycle, go to DONE.
- DONE: hold until the next start or vblank.
- rowram_swap: disp_bank toggles every pulse, in any state. Then:
  - next_row < ROWS: start a fill.
  - next_row >= ROWS: go to IDLE.
- vblank_start: go to IDLE. Bank is unchanged unless a swap arrives in the same cycle.
- vblank_end_soon: start a fill of next_row into the current write bank. Bank does not toggle.
- Fill aborted by swap, vblank_start or vblank_end_soon while in REQ or FILL: overrun <= 1. Sticky until rst.
- Simultaneous swap + vblank_start: bank toggles, state goes to IDLE, no fill starts.
- Simultaneous swap + pixel handshake: the pixel is dropped (not written), the new fill starts, overrun is set.
- pix_ready is 0 outside FILL. The pipeline must hold pix_valid/pix_data until accepted.
- wr_ptr width is 9 bits. It never exceeds ROW_W-1.

Decomposition:
- ppu_pkg holds:
  - constants ROW_W=320, ROWS=240, PIX_W=10
  - typedef rowbuf_state_t enum {IDLE, REQ, FILL, DONE}
  - typedef pix_t logic [PIX_W-1:0]
- Sub-module rowram_bank: simple dual-port 1R1W RAM, registered read, ROW_W x PIX_W, inferred block RAM. Instantiate it twice, with the read mux on a registered bank select.

Test Plan:
- Reset, then read addr 0..319 -> rowram_rddata=0; all handshake outputs 0, overrun=0.
- vblank_end_soon with next_row=0 -> row_req_num=0. After ready, stream 320 pixels of value = column%1024 -> row_done one cycle after the 320th write; pix_ready drops.
- rowram_swap with next_row=1 -> reading addr 5 the next cycle returns 5 and addr 319 returns 319. row_req_num=1 and the old bank is being filled.
- rowram_swap after only 100 pixels accepted -> overrun=1, fill restarts at wr_ptr=0 for the new next_row, bank toggles.
- rowram_swap with next_row=240, then vblank_start -> state IDLE, no row_req_valid, bank toggled exactly once.
- pix_valid toggling 1/0 every cycle with row_req_ready held low for 3 cycles -> no writes before acceptance. Exactly 320 writes land in the correct order, and rowram_rdaddr=320 returns 0.
